// File: rtl/spi_reg_pkg.sv
// Shared constants for the SPI-attached register bank.
// Contents:
//   - register address map (3-bit address space)
//   - CTRL register bit positions
package spi_reg_pkg;

  localparam logic [2:0] ADDR_CTRL  = 3'd0;
  localparam logic [2:0] ADDR_CFG0  = 3'd1;
  localparam logic [2:0] ADDR_EVT   = 3'd5;
  localparam logic [2:0] ADDR_HWIN  = 3'd6;
  localparam logic [2:0] ADDR_WRCNT = 3'd7;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

endpackage

// File: rtl/w1c_flags.sv
// Sticky event flags with write-one-to-clear.
// Ports:
//   clk, rstb  - clock, synchronous active-low reset
//   ena        - update enable; flags hold when low
//   set_i      - per-bit set requests (already gated by the caller)
//   clr_i      - per-bit clear requests (the write data of a W1C write)
//   flags_o    - current flag values
// A bit that is set and cleared in the same cycle ends up set, so an
// event arriving during a clear is never lost.
module w1c_flags #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         ena,
  input  logic [W-1:0] set_i,
  input  logic [W-1:0] clr_i,
  output logic [W-1:0] flags_o
);

  logic [W-1:0] flags_reg;
  logic [W-1:0] flags_next;

  assign flags_next = (flags_reg & ~clr_i) | set_i;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      flags_reg <= '0;
    end else if (ena) begin
      flags_reg <= flags_next;
    end
  end

  assign flags_o = flags_reg;

endmodule

// File: rtl/spi_reg_bank.sv
// Register bank behind the SPI slave register interface.
// Ports:
//   clk, rstb    - clock, synchronous active-low reset
//   ena          - global enable; all state holds when low
//   reg_addr_i   - register address
//   reg_wdata_i  - write data
//   reg_we_i     - single-cycle write strobe
//   reg_rdata_o  - combinational read data for reg_addr_i (pre-write value)
//   status_o     - registered status byte for the start of each frame
//   cfg_o        - CFGn at bits [n*REG_W +: REG_W]
//   evt_i        - one-cycle event pulses captured into EVT
//   hw_in_i      - synchronous hardware inputs sampled into HWIN
//   irq_o        - registered interrupt: CTRL.irq_en & |EVT
// Map: 0 CTRL, 1..4 CFG0..3, 5 EVT (W1C), 6 HWIN (RO), 7 WRCNT (RO, write clears).
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W  = 3,
  parameter int REG_W   = 8,
  parameter int NUM_CFG = 4
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     ena,
  input  logic [ADDR_W-1:0]        reg_addr_i,
  input  logic [REG_W-1:0]         reg_wdata_i,
  input  logic                     reg_we_i,
  output logic [REG_W-1:0]         reg_rdata_o,
  output logic [7:0]               status_o,
  output logic [NUM_CFG*REG_W-1:0] cfg_o,
  input  logic [REG_W-1:0]         evt_i,
  input  logic [REG_W-1:0]         hw_in_i,
  output logic                     irq_o
);

  logic              wr_en;
  logic [REG_W-1:0]  ctrl_reg;
  logic [REG_W-1:0]  hwin_reg;
  logic [REG_W-1:0]  wrcnt_reg;
  logic [REG_W-1:0]  wrcnt_next;
  logic [REG_W-1:0]  evt_flags;
  logic [REG_W-1:0]  evt_set;
  logic [REG_W-1:0]  evt_clr;
  logic [ADDR_W-1:0] last_addr_reg;
  logic [ADDR_W-1:0] last_addr_next;
  logic              irq_reg;
  logic              irq_next;
  logic [7:0]        status_reg;
  logic [7:0]        status_next;

  assign wr_en = ena & reg_we_i;

  // Configuration registers, each driving its own slice of cfg_o.
  for (genvar gi = 0; gi < NUM_CFG; gi++) begin : g_cfg
    logic [REG_W-1:0] cfg_reg;
    always_ff @(posedge clk) begin
      if (!rstb) begin
        cfg_reg <= '0;
      end else if (wr_en && reg_addr_i == ADDR_W'(int'(ADDR_CFG0) + gi)) begin
        cfg_reg <= reg_wdata_i;
      end
    end
    assign cfg_o[gi*REG_W +: REG_W] = cfg_reg;
  end

  // Events are only captured while CTRL.enable is set.
  assign evt_set = ctrl_reg[CTRL_EN] ? evt_i : '0;
  assign evt_clr = (wr_en && reg_addr_i == ADDR_EVT) ? reg_wdata_i : '0;

  w1c_flags #(.W(REG_W)) u_evt (
    .clk     (clk),
    .rstb    (rstb),
    .ena     (ena),
    .set_i   (evt_set),
    .clr_i   (evt_clr),
    .flags_o (evt_flags)
  );

  // Write counter: address 7 clears it without counting itself; every
  // other accepted write counts, saturating at all-ones.
  always_comb begin
    wrcnt_next = wrcnt_reg;
    if (wr_en) begin
      if (reg_addr_i == ADDR_WRCNT) begin
        wrcnt_next = '0;
      end else if (wrcnt_reg != '1) begin
        wrcnt_next = wrcnt_reg + 1'b1;
      end
    end
  end

  assign last_addr_next = wr_en ? reg_addr_i : last_addr_reg;
  assign irq_next       = ctrl_reg[CTRL_IRQ_EN] & (|evt_flags);
  assign status_next    = {irq_next, ctrl_reg[CTRL_EN], last_addr_next, wrcnt_next[2:0]};

  always_ff @(posedge clk) begin
    if (!rstb) begin
      ctrl_reg      <= '0;
      hwin_reg      <= '0;
      wrcnt_reg     <= '0;
      last_addr_reg <= '0;
      irq_reg       <= 1'b0;
      status_reg    <= '0;
    end else if (ena) begin
      if (wr_en && reg_addr_i == ADDR_CTRL) begin
        ctrl_reg <= reg_wdata_i;
      end
      hwin_reg      <= hw_in_i;
      wrcnt_reg     <= wrcnt_next;
      last_addr_reg <= last_addr_next;
      irq_reg       <= irq_next;
      status_reg    <= status_next;
    end
  end

  // Read mux reflects register contents before any write this cycle.
  always_comb begin
    reg_rdata_o = '0;
    case (reg_addr_i)
      ADDR_CTRL:  reg_rdata_o = ctrl_reg;
      ADDR_EVT:   reg_rdata_o = evt_flags;
      ADDR_HWIN:  reg_rdata_o = hwin_reg;
      ADDR_WRCNT: reg_rdata_o = wrcnt_reg;
      default: begin
        for (int i = 0; i < NUM_CFG; i++) begin
          if (reg_addr_i == ADDR_W'(int'(ADDR_CFG0) + i)) begin
            reg_rdata_o = cfg_o[i*REG_W +: REG_W];
          end
        end
      end
    endcase
  end

  assign irq_o    = irq_reg;
  assign status_o = status_reg;

endmodule
